// File: rtl/rc6_pipe_rotator.sv
// Pipelined data-dependent rotator for the RC6 round datapath.
// Stage k rotates by 2^k when bit k of the transaction's amount is set.
// Direction, the remaining amount bits and the tag travel with the word.
// All stages advance together only when the output slot is free or is being consumed.
module rc6_pipe_rotator #(
  parameter int W     = 32,
  parameter int LOG2W = $clog2(W),
  parameter int TAG_W = 4
) (
  input  logic             inClk,
  input  logic             inRst,
  input  logic             inValid,
  output logic             inReady,
  input  logic             inDir,
  input  logic [LOG2W-1:0] inRotValue,
  input  logic [W-1:0]     inData,
  input  logic [TAG_W-1:0] inTag,
  output logic             outValid,
  input  logic             outReady,
  output logic [W-1:0]     outData,
  output logic [TAG_W-1:0] outTag
);

  if (W < 4 || W > 128 || (W & (W - 1)) != 0) begin : g_bad_width
    $error("rc6_pipe_rotator: W must be a power of two in 4..128");
  end

  if (LOG2W != $clog2(W)) begin : g_bad_log2w
    $error("rc6_pipe_rotator: LOG2W is derived from W and must not be overridden");
  end

  // Conditional rotate by 2^k; right rotation uses its own shift pair rather than a negated amount.
  function automatic logic [W-1:0] rot_pow2(input logic [W-1:0] d, input logic en,
                                            input logic dir, input int k);
    logic [W-1:0] left_r;
    logic [W-1:0] right_r;
    int           s;
    s       = 1 << k;
    left_r  = (d << s) | (d >> (W - s));
    right_r = (d >> s) | (d << (W - s));
    if (!en) return d;
    return dir ? right_r : left_r;
  endfunction

  logic             adv;

  logic [LOG2W-1:0] vld_q, vld_d;
  logic [LOG2W-1:0] dir_q, dir_d;
  logic [LOG2W-1:0] amt_q  [LOG2W];
  logic [LOG2W-1:0] amt_d  [LOG2W];
  logic [W-1:0]     data_q [LOG2W];
  logic [W-1:0]     data_d [LOG2W];
  logic [TAG_W-1:0] tag_q  [LOG2W];
  logic [TAG_W-1:0] tag_d  [LOG2W];

  logic [LOG2W-1:0] src_vld;
  logic [LOG2W-1:0] src_dir;
  logic [LOG2W-1:0] src_amt  [LOG2W];
  logic [W-1:0]     src_data [LOG2W];
  logic [TAG_W-1:0] src_tag  [LOG2W];

  // The final stage's direction and leftover amount have no consumer.
  logic             unused_tail;
  assign unused_tail = ^{dir_q[LOG2W-1], amt_q[LOG2W-1]};

  // Bubbles are not collapsed: the whole pipe moves or the whole pipe holds.
  assign adv      = outReady | ~vld_q[LOG2W-1];
  assign inReady  = adv;

  assign outValid = vld_q[LOG2W-1];
  assign outData  = data_q[LOG2W-1];
  assign outTag   = tag_q[LOG2W-1];

  // Feed of each stage: the ports for S0, the previous stage's registers otherwise.
  always_comb begin
    src_vld[0]  = inValid;
    src_dir[0]  = inDir;
    src_amt[0]  = inRotValue;
    src_data[0] = inData;
    src_tag[0]  = inTag;
    for (int k = 1; k < LOG2W; k++) begin
      src_vld[k]  = vld_q[k-1];
      src_dir[k]  = dir_q[k-1];
      src_amt[k]  = amt_q[k-1];
      src_data[k] = data_q[k-1];
      src_tag[k]  = tag_q[k-1];
    end
  end

  // Next state: hold on stall, otherwise consume the low amount bit and pass the rest along.
  always_comb begin
    for (int k = 0; k < LOG2W; k++) begin
      vld_d[k]  = vld_q[k];
      dir_d[k]  = dir_q[k];
      amt_d[k]  = amt_q[k];
      data_d[k] = data_q[k];
      tag_d[k]  = tag_q[k];
      if (adv) begin
        vld_d[k]  = src_vld[k];
        dir_d[k]  = src_dir[k];
        amt_d[k]  = src_amt[k] >> 1;
        data_d[k] = rot_pow2(src_data[k], src_amt[k][0], src_dir[k], k);
        tag_d[k]  = src_tag[k];
      end
    end
  end

  // Stage registers; reset clears every valid and the visible output word and tag.
  always_ff @(posedge inClk) begin
    if (inRst) begin
      vld_q             <= '0;
      data_q[LOG2W-1]   <= '0;
      tag_q[LOG2W-1]    <= '0;
    end else begin
      vld_q <= vld_d;
      dir_q <= dir_d;
      for (int k = 0; k < LOG2W; k++) begin
        amt_q[k]  <= amt_d[k];
        data_q[k] <= data_d[k];
        tag_q[k]  <= tag_d[k];
      end
    end
  end

endmodule

// File: tb/tb_rc6_pipe_rotator.sv
// Bench for rc6_pipe_rotator: directed rotations, random traffic with
// backpressure against a scoreboard, mid-stream reset, and W=16/W=64 builds.
module tb_rc6_pipe_rotator;

  localparam int W  = 32;
  localparam int LW = 5;
  localparam int TW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          in_valid, in_ready, in_dir;
  logic [LW-1:0] in_rot;
  logic [W-1:0]  in_data;
  logic [TW-1:0] in_tag;
  logic          out_valid, out_ready;
  logic [W-1:0]  out_data;
  logic [TW-1:0] out_tag;

  logic          v16, rdy16, dir16, ov16, ordy16;
  logic [3:0]    amt16, tag16, ot16;
  logic [15:0]   dat16, od16;

  logic          v64, rdy64, dir64, ov64, ordy64;
  logic [5:0]    amt64;
  logic [3:0]    tag64, ot64;
  logic [63:0]   dat64, od64;

  rc6_pipe_rotator #(.W(32), .TAG_W(TW)) dut (
    .inClk(clk), .inRst(rst), .inValid(in_valid), .inReady(in_ready), .inDir(in_dir),
    .inRotValue(in_rot), .inData(in_data), .inTag(in_tag), .outValid(out_valid),
    .outReady(out_ready), .outData(out_data), .outTag(out_tag));

  rc6_pipe_rotator #(.W(16), .TAG_W(TW)) dut16 (
    .inClk(clk), .inRst(rst), .inValid(v16), .inReady(rdy16), .inDir(dir16),
    .inRotValue(amt16), .inData(dat16), .inTag(tag16), .outValid(ov16),
    .outReady(ordy16), .outData(od16), .outTag(ot16));

  rc6_pipe_rotator #(.W(64), .TAG_W(TW)) dut64 (
    .inClk(clk), .inRst(rst), .inValid(v64), .inReady(rdy64), .inDir(dir64),
    .inRotValue(amt64), .inData(dat64), .inTag(tag64), .outValid(ov64),
    .outReady(ordy64), .outData(od64), .outTag(ot64));

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [W-1:0]  data;
  } exp_t;

  exp_t          sbq[$];
  logic          stall_prev = 1'b0;
  logic [W-1:0]  held_data;
  logic [TW-1:0] held_tag;
  bit            done;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: rotate the doubled word left, right by n being left by (W-n) mod W.
  function automatic logic [W-1:0] ref_rot(input logic [W-1:0] d, input logic [LW-1:0] n,
                                           input logic dir);
    int          a;
    logic [63:0] t;
    a = dir ? (W - int'(n)) % W : int'(n) % W;
    t = {d, d} << a;
    return t[63:32];
  endfunction

  // Output monitor: scoreboard order/values and stability while stalled.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", 64'(out_valid), 64'(1));
        chk("hold_data", 64'(out_data), 64'(held_data));
        chk("hold_tag", 64'(out_tag), 64'(held_tag));
      end
      if (out_valid && out_ready) begin
        chk("queue_depth", 64'(sbq.size() > 0), 64'(1));
        if (sbq.size() > 0) begin
          exp_t e;
          e = sbq.pop_front();
          chk("out_data", 64'(out_data), 64'(e.data));
          chk("out_tag", 64'(out_tag), 64'(e.tag));
        end
      end
      stall_prev = out_valid && !out_ready;
      held_data  = out_data;
      held_tag   = out_tag;
    end
  end

  task automatic send(input logic dir, input logic [LW-1:0] amt, input logic [W-1:0] data,
                      input logic [TW-1:0] tag, input logic [W-1:0] expv);
    bit acc = 1'b0;
    in_valid = 1'b1;
    in_dir   = dir;
    in_rot   = amt;
    in_data  = data;
    in_tag   = tag;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_dir   = 1'($urandom_range(0, 1));
    in_rot   = LW'($urandom_range(0, 31));
    in_data  = $urandom;
    in_tag   = TW'($urandom_range(0, 15));
    if (acc) sbq.push_back({tag, expv});
    else chk("send_timeout", 64'(acc), 64'(1));
  endtask

  task automatic send_rand();
    logic          dr;
    logic [LW-1:0] a;
    logic [W-1:0]  d;
    logic [TW-1:0] t;
    dr = 1'($urandom_range(0, 1));
    a  = LW'($urandom_range(0, 31));
    d  = $urandom;
    t  = TW'($urandom_range(0, 15));
    send(dr, a, d, t, ref_rot(d, a, dr));
  endtask

  task automatic lat_test(input string name, input logic dir, input logic [LW-1:0] amt,
                          input logic [W-1:0] data, input logic [TW-1:0] tag,
                          input logic [W-1:0] expv);
    int n = 0;
    send(dir, amt, data, tag, expv);
    while (!out_valid && n < 12) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({name, "_lat"}, 64'(n), 64'(4));
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, 64'(sbq.size()), 64'(0));
  endtask

  initial begin
    int n;
    rst = 1'b1;
    in_valid = 1'b0; in_dir = 1'b0; in_rot = '0; in_data = '0; in_tag = '0; out_ready = 1'b1;
    v16 = 1'b0; dir16 = 1'b0; amt16 = '0; dat16 = '0; tag16 = '0; ordy16 = 1'b1;
    v64 = 1'b0; dir64 = 1'b0; amt64 = '0; dat64 = '0; tag64 = '0; ordy64 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    rst = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_out_tag", 64'(out_tag), 64'(0));

    // Directed rotations with latency.
    lat_test("rotl4", 1'b0, 5'd4, 32'h12345678, 4'h1, 32'h23456781);
    lat_test("rotl31", 1'b0, 5'd31, 32'h80000001, 4'h2, 32'hC0000000);
    lat_test("rotr4", 1'b1, 5'd4, 32'h12345678, 4'h3, 32'h81234567);
    lat_test("rotr1", 1'b1, 5'd1, 32'h00000001, 4'h4, 32'h80000000);
    lat_test("zero_l", 1'b0, 5'd0, 32'hDEADBEEF, 4'h5, 32'hDEADBEEF);
    lat_test("zero_r", 1'b1, 5'd0, 32'hA5C30F96, 4'h6, 32'hA5C30F96);
    drain("directed_drain");

    // Back-to-back: eight results on consecutive cycles.
    for (int i = 0; i < 8; i++) send_rand();
    repeat (4) @(posedge clk);
    #1;
    chk("b2b_pending", 64'(sbq.size()), 64'(1));
    @(posedge clk);
    #1;
    chk("b2b_done", 64'(sbq.size()), 64'(0));

    // Fill under stall, hold six cycles, then release.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_rand();
    for (int i = 0; i < 6; i++) begin
      chk("bp_in_ready", 64'(in_ready), 64'(0));
      chk("bp_out_valid", 64'(out_valid), 64'(1));
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) send_rand();
    drain("bp_drain");

    // Random traffic with random backpressure and bubbles.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          send_rand();
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = ($urandom_range(0, 2) != 0);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain("rand_drain");

    // Reset with three words in flight and a word offered during reset.
    for (int i = 0; i < 3; i++) send_rand();
    rst = 1'b1;
    in_valid = 1'b1; in_data = 32'hFFFF0000; in_rot = 5'd3; in_tag = 4'hF;
    @(negedge clk);
    chk("rst_mid_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    sbq.delete();
    chk("rst_mid_valid", 64'(out_valid), 64'(0));
    chk("rst_mid_data", 64'(out_data), 64'(0));
    chk("rst_mid_tag", 64'(out_tag), 64'(0));
    repeat (8) @(posedge clk);
    #1;
    lat_test("post_rst", 1'b0, 5'd8, 32'h0F0F1234, 4'h9, 32'h0F12340F);
    drain("post_rst_drain");

    // W=16: 0xABCD left by 8, depth 4.
    v16 = 1'b1; dir16 = 1'b0; amt16 = 4'd8; dat16 = 16'hABCD; tag16 = 4'hA;
    @(negedge clk);
    chk("w16_ready", 64'(rdy16), 64'(1));
    @(posedge clk);
    #1;
    v16 = 1'b0;
    n = 0;
    while (!ov16 && n < 12) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("w16_lat", 64'(n), 64'(3));
    chk("w16_data", 64'(od16), 64'(16'hCDAB));
    chk("w16_tag", 64'(ot16), 64'(4'hA));

    // W=64: 0x0123456789ABCDEF right by 36, depth 6.
    v64 = 1'b1; dir64 = 1'b1; amt64 = 6'd36; dat64 = 64'h0123456789ABCDEF; tag64 = 4'hC;
    @(negedge clk);
    chk("w64_ready", 64'(rdy64), 64'(1));
    @(posedge clk);
    #1;
    v64 = 1'b0;
    n = 0;
    while (!ov64 && n < 12) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("w64_lat", 64'(n), 64'(5));
    chk("w64_data", od64, 64'h789ABCDEF0123456);
    chk("w64_tag", 64'(ot64), 64'(4'hC));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
